// File: rtl/ps2_tx.sv
// Host-side PS/2 transmitter: sends one command byte to a PS/2 device using the
// host-to-device sequence (inhibit, request-to-send, device-clocked data,
// parity and stop, then device acknowledge). The shared open-drain pads are
// driven through active-high pull-low enables.
//
// Ports
//   clk, rst          system clock, asynchronous active-low reset
//   tx_valid/tx_ready command byte handshake; accept = tx_valid & tx_ready
//   tx_data           command byte, sampled on accept
//   ps2_clk/ps2_data  asynchronous pad inputs
//   ps2_clk_oe        1 = pull ps2_clk low
//   ps2_data_oe       1 = pull ps2_data low
//   busy              ~tx_ready, lets the neighbouring receiver ignore our frame
//   done              1-cycle pulse: byte acknowledged and bus idle
//   err               1-cycle pulse: NACK or timeout
module ps2_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned CNT_W          = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned BIT_W = 4;
  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [BIT_W-1:0] DATA_FALLS   = BIT_W'(8);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RTS,
    ST_SEND,
    ST_ACK,
    ST_WAIT_IDLE
  } state_t;

  state_t           state, state_nxt;
  logic [7:0]       shift, shift_nxt;
  logic             parity, parity_nxt;
  logic [BIT_W-1:0] bit_cnt, bit_nxt;
  logic [CNT_W-1:0] timer, timer_nxt, timer_inc;
  logic             clk_oe_nxt, data_oe_nxt;
  logic             done_nxt, err_nxt, ready_nxt, busy_nxt;
  logic             timed_out;

  logic clk_s1, clk_s2, clk_prev;
  logic data_s1, data_s2;
  logic fall;

  // Pad synchronizers; the extra clock stage gives falling-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      data_s1  <= ps2_data;
      data_s2  <= data_s1;
    end
  end

  assign fall = clk_prev & ~clk_s2;

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      shift       <= '0;
      parity      <= 1'b0;
      bit_cnt     <= '0;
      timer       <= '0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      tx_ready    <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= state_nxt;
      shift       <= shift_nxt;
      parity      <= parity_nxt;
      bit_cnt     <= bit_nxt;
      timer       <= timer_nxt;
      ps2_clk_oe  <= clk_oe_nxt;
      ps2_data_oe <= data_oe_nxt;
      tx_ready    <= ready_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      err         <= err_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift;
    parity_nxt  = parity;
    bit_nxt     = bit_cnt;
    timer_nxt   = timer;
    clk_oe_nxt  = ps2_clk_oe;
    data_oe_nxt = ps2_data_oe;
    done_nxt    = 1'b0;
    err_nxt     = 1'b0;
    timer_inc   = timer + CNT_W'(1);
    timed_out   = (timer == TIMEOUT_LAST);

    case (state)
      ST_IDLE: begin
        clk_oe_nxt  = 1'b0;
        data_oe_nxt = 1'b0;
        if (tx_valid && tx_ready) begin
          shift_nxt  = tx_data;
          parity_nxt = ~^tx_data;
          bit_nxt    = '0;
          timer_nxt  = '0;
          clk_oe_nxt = 1'b1;
          state_nxt  = ST_INHIBIT;
        end
      end

      // The RTS cycle is the last of the INHIBIT_CYCLES clock-low cycles,
      // so leave one count early and let the counter rest at its last value.
      ST_INHIBIT: begin
        timer_nxt = timer_inc;
        if (timer_inc == INHIBIT_LAST) begin
          data_oe_nxt = 1'b1;
          state_nxt   = ST_RTS;
        end
      end

      ST_RTS: begin
        clk_oe_nxt = 1'b0;
        timer_nxt  = '0;
        bit_nxt    = '0;
        state_nxt  = ST_SEND;
      end

      ST_SEND: begin
        if (fall) begin
          timer_nxt = '0;
          bit_nxt   = bit_cnt + BIT_W'(1);
          if (bit_cnt < DATA_FALLS) begin
            data_oe_nxt = ~shift[0];
            shift_nxt   = {1'b0, shift[7:1]};
          end else if (bit_cnt == DATA_FALLS) begin
            data_oe_nxt = ~parity;
          end else begin
            data_oe_nxt = 1'b0;
            state_nxt   = ST_ACK;
          end
        end else if (timed_out) begin
          clk_oe_nxt  = 1'b0;
          data_oe_nxt = 1'b0;
          err_nxt     = 1'b1;
          state_nxt   = ST_IDLE;
        end else begin
          timer_nxt = timer_inc;
        end
      end

      ST_ACK: begin
        if (fall) begin
          timer_nxt = '0;
          if (!data_s2) begin
            state_nxt = ST_WAIT_IDLE;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = ST_IDLE;
          end
        end else if (timed_out) begin
          clk_oe_nxt  = 1'b0;
          data_oe_nxt = 1'b0;
          err_nxt     = 1'b1;
          state_nxt   = ST_IDLE;
        end else begin
          timer_nxt = timer_inc;
        end
      end

      ST_WAIT_IDLE: begin
        if (clk_s2 && data_s2) begin
          done_nxt  = 1'b1;
          state_nxt = ST_IDLE;
        end else if (fall) begin
          timer_nxt = '0;
        end else if (timed_out) begin
          clk_oe_nxt  = 1'b0;
          data_oe_nxt = 1'b0;
          err_nxt     = 1'b1;
          state_nxt   = ST_IDLE;
        end else begin
          timer_nxt = timer_inc;
        end
      end

      default: begin
        clk_oe_nxt  = 1'b0;
        data_oe_nxt = 1'b0;
        state_nxt   = ST_IDLE;
      end
    endcase

    // Ready only opens the cycle after a done/err pulse.
    ready_nxt = (state_nxt == ST_IDLE) && !done_nxt && !err_nxt;
    busy_nxt  = !ready_nxt;
  end

endmodule
